// File: rtl/fetch_unit.sv
// fetch_unit: PC register and req/ack instruction fetch for the single-cycle core.
// Optional fetch timeout with sticky FetchFault enabled by FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCPlus8,
    output logic        FetchFault
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        unused_ok;

    assign IMemReq    = state == FETCH;
    assign InstrValid = state == EXEC;
    assign IMemAddr   = pc;
    assign PC         = pc;
    assign PCPlus4    = pc + 32'd4;
    assign PCPlus8    = pc + 32'd8;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0]       FAULT = 2'd3;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             fault;

    assign timeout    = state == FETCH && !IMemAck && cnt == LAST;
    assign FetchFault = fault;
    assign unused_ok  = ^Result[1:0];

    // Counter is held at zero outside FETCH, so every fetch starts a fresh budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            cnt   <= (state == FETCH && !IMemAck && !timeout) ? cnt + 1'b1 : '0;
            fault <= fault | timeout;
        end
    end
`else
    assign FetchFault = 1'b0;
    assign unused_ok  = ^{Result[1:0], CNT_W'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            Instr <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (IMemAck) begin
                        Instr <= IMemRData;
                        state <= EXEC;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout) state <= FAULT;
`endif
                end
                EXEC: begin
                    if (!Stall) begin
                        pc    <= PCSrc ? {Result[31:2], 2'b00} : pc + 32'd4;
                        state <= FETCH;
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench; the bench plays instruction memory
// and tracks the architectural PC per instruction.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] Result = '0;
    logic        Stall = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemRData = '0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] PCPlus8;
    logic        FetchFault;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = 32'h0;

    fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .Result(Result), .Stall(Stall),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData),
        .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
        .PCPlus8(PCPlus8), .FetchFault(FetchFault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One instruction: w wait states (-1 = random), data d, br: -1 random, 0 sequential, 1 jump to res.
    task automatic do_instr(input int w, input logic [31:0] d, input int br, input logic [31:0] res);
        int g = 0;
        int waits = (w < 0) ? int'($urandom_range(0, 3)) : w;
        int stalls = $urandom_range(0, 2);
        logic take;
        logic [31:0] tgt;
        while (!IMemReq && g < 4) begin
            @(negedge clk);
            g++;
        end
        check("req_seen", {31'b0, IMemReq}, 32'd1);
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req", {31'b0, IMemReq}, 32'd1);
            check("fetch_addr", IMemAddr, exp_pc);
            check("fetch_valid", {31'b0, InstrValid}, 32'd0);
            IMemAck = (i == waits);
            IMemRData = (i == waits) ? d : $urandom;
            @(negedge clk);
        end
        for (int i = 0; i <= stalls; i++) begin
            check("exec_valid", {31'b0, InstrValid}, 32'd1);
            check("exec_req", {31'b0, IMemReq}, 32'd0);
            check("exec_instr", Instr, d);
            check("exec_pc", PC, exp_pc);
            check("exec_pc4", PCPlus4, exp_pc + 32'd4);
            check("exec_pc8", PCPlus8, exp_pc + 32'd8);
            IMemAck = $urandom;
            IMemRData = $urandom;
            Stall = (i != stalls);
            take = (br < 0) ? 1'($urandom) : br[0];
            tgt = (br < 0) ? $urandom : res;
            PCSrc = (i != stalls) ? 1'($urandom) : take;
            Result = (i != stalls) ? $urandom : tgt;
            @(negedge clk);
        end
        exp_pc = take ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        Stall = 1'b0;
        PCSrc = 1'b0;
        IMemAck = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, IMemReq}, 32'd0);
        check("rst_valid", {31'b0, InstrValid}, 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_pc", PC, 32'd0);
        check("rst_fault", {31'b0, FetchFault}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        do_instr(0, 32'hE280_1005, 0, 32'h0);
        do_instr(3, $urandom, 1, 32'h0000_0023);
        do_instr(-1, $urandom, 1, 32'h0000_0103);
        check("branch_target", exp_pc, 32'h0000_0100);
        do_instr(-1, $urandom, 1, 32'h0000_0023);
        do_instr(-1, $urandom, 0, 32'h0);
        do_instr(-1, $urandom, 1, 32'hFFFF_FFFF);
        do_instr(-1, $urandom, 0, 32'h0);
        do_instr(-1, $urandom, 1, 32'h0000_0040);
        for (int i = 0; i < 40; i++) do_instr(-1, $urandom, -1, 32'h0);
        do_instr(-1, $urandom, 1, 32'h0000_0040);
        // Reset in the middle of a fetch, ack arriving right after release.
        check("mid_addr", IMemAddr, 32'h0000_0040);
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, IMemReq}, 32'd0);
        check("mid_rst_pc", PC, 32'd0);
        check("mid_rst_instr", Instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        IMemAck = 1'b1;
        IMemRData = 32'hDEAD_BEEF;
        @(negedge clk);
        IMemAck = 1'b0;
        check("restart_valid", {31'b0, InstrValid}, 32'd0);
        check("restart_instr", Instr, 32'd0);
        exp_pc = 32'h0;
        for (int i = 0; i < 10; i++) do_instr(-1, $urandom, -1, 32'h0);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check("to_req", {31'b0, IMemReq}, 32'd1);
            check("to_fault_lo", {31'b0, FetchFault}, 32'd0);
            IMemAck = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check("to_fault_hi", {31'b0, FetchFault}, 32'd1);
            check("to_req_off", {31'b0, IMemReq}, 32'd0);
            check("to_valid_off", {31'b0, InstrValid}, 32'd0);
            check("to_pc_frozen", PC, exp_pc);
            IMemAck = 1'b1;
            @(negedge clk);
        end
        IMemAck = 1'b0;
        reset = 1'b1;
        #1;
        check("to_fault_clr", {31'b0, FetchFault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage feeding the decoder/control unit and datapath of the ARM-subset single-cycle core.
- Owns the PC register and fetches from an instruction memory over a req/ack handshake, so memory may insert wait states.
- Presents a latched Instr with a one-cycle-per-instruction InstrValid execute window.
- Applies the PCSrc/Result redirect computed by control and datapath.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset (bits [1:0] must be 0).
- TIMEOUT_CYCLES, 255, maximum cycles FETCH waits for IMemAck (used only with the optional feature).
- CNT_W, 8, width of the wait-cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCSrc  in  1  from control: redirect PC to Result at the end of this instruction (already condition-qualified).
- Result  in  32  from datapath: branch target or ALU/load value written to R15.
- Stall  in  1  from datapath: hold the current instruction in execute (e.g. data memory busy).
- IMemReq  out  1  instruction memory request.
- IMemAddr  out  32  fetch address, word aligned.
- IMemAck  in  1  memory response valid; IMemRData is sampled in the same cycle.
- IMemRData  in  32  fetched instruction word.
- Instr  out  32  latched instruction for control/datapath.
- InstrValid  out  1  high during the execute cycle(s). Control's RegWrite/MemWrite/flag writes are committed only while this is high.
- PC  out  32  address of Instr.
- PCPlus4  out  32  PC+4.
- PCPlus8  out  32  PC+8, the architectural R15 read value.
- FetchFault  out  1  sticky fetch timeout (optional feature; otherwise tied 0).

Behaviour:
- States: IDLE, FETCH, EXEC, FAULT (FAULT exists only with the optional feature).
- Reset values: state=IDLE, PC=RESET_PC, Instr=0, IMemReq=0, InstrValid=0, FetchFault=0, wait counter=0.
- IDLE: unconditional move to FETCH on the next edge.
- FETCH behaviour:
  - IMemReq=1 and IMemAddr=PC, held stable until ack.
  - On a cycle with IMemAck=1: Instr<=IMemRData, state->EXEC.
  - Zero-wait ack (ack in the first FETCH cycle) is legal and gives a minimum fetch latency of 1 cycle.
- IMemAck while IMemReq=0 is ignored and Instr is unchanged.
- EXEC behaviour:
  - IMemReq=0 and InstrValid=1.
  - While Stall=1: remain in EXEC, holding PC and Instr.
  - When Stall=0: on the edge PC<={Result[31:2],2'b00} if PCSrc=1, otherwise PC<=PC+4; state->FETCH.
- Result[1:0] are silently dropped. PCSrc is sampled only in the EXEC cycle with Stall=0.
- Throughput with zero-wait memory is one instruction per 2 cycles.
- PC arithmetic is 32-bit modulo: PC=32'hFFFF_FFFC advances to 0. PCPlus4 and PCPlus8 wrap the same way.
- IMemAddr=PC in all states. Meaningful only while IMemReq=1.
- Reset asserted in any state, including mid-FETCH with an ack pending: immediate return to reset values, IMemReq drops combinationally-free (registered state=IDLE). Any ack arriving during or in the cycle after reset is ignored.
- Instr, PC, PCPlus4 and PCPlus8 are stable for the whole EXEC window.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- When defined:
  - The wait counter increments each FETCH cycle without ack and clears on entering FETCH.
  - When the count reaches TIMEOUT_CYCLES with no ack: FetchFault<=1, state->FAULT.
  - FAULT: IMemReq=0, InstrValid=0, PC frozen. Only reset exits.
- When undefined: no counter, no FAULT state, FetchFault tied 0, FETCH waits indefinitely.

Test Plan:
- Reset release, RESET_PC=0, memory acks in the first cycle with 32'hE280_1005 -> IMemAddr=0; Instr=32'hE280_1005 and InstrValid=1 in cycle 2; next IMemAddr=4; PCPlus8=8 during EXEC.
- Memory with 3 wait states -> IMemReq and IMemAddr held stable 4 cycles; InstrValid rises exactly 1 cycle after ack; Instr equals the acked data.
- EXEC at PC=0x20 with PCSrc=1, Result=32'h0000_0103 -> next IMemAddr=32'h0000_0100; with PCSrc=0 -> 32'h0000_0024.
- Stall=1 for 2 cycles in EXEC -> InstrValid high 3 cycles, PC and Instr unchanged, no IMemReq; advance occurs on the edge after Stall falls.
- Reset pulse mid-FETCH (PC=0x40) with ack arriving the next cycle -> IMemReq=0, PC=RESET_PC, ack ignored; fetch restarts at RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> FetchFault=1 after 4 FETCH cycles; IMemReq=0 thereafter; cleared only by reset.
